// File: rtl/uart_arb_defs_pkg.sv
// Shared definitions for the UART TX arbiter.
//   - arbiter FSM state encodings
//   - header byte base (header = HDR_BASE | requester index)
//   - maximum requester count and the index type sized for it
// Optional feature macro used by the arbiter: UART_ARB_FRAME_HDR_EN
package uart_arb_defs_pkg;

  localparam int         N_REQ_MAX = 8;
  localparam int         IDX_W     = $clog2(N_REQ_MAX);
  localparam logic [7:0] HDR_BASE  = 8'hA0;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_GRANT = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  function automatic logic [7:0] hdr_byte(input idx_t idx);
    return HDR_BASE | 8'(idx);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection (purely combinational).
// Ports:
//   req      in   N_REQ   request vector
//   ptr      in   idx_t   search starts at this index and wraps
//   win_oh   out  N_REQ   one-hot winner (zero when no request)
//   win_idx  out  idx_t   index of the winner
//   win_any  out  1       at least one request present
module rr_pick
  import uart_arb_defs_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  idx_t             ptr,
  output logic [N_REQ-1:0] win_oh,
  output idx_t             win_idx,
  output logic             win_any
);

  always_comb begin
    int j;
    j       = 0;
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!win_any && req[j]) begin
        win_any   = 1'b1;
        win_oh[j] = 1'b1;
        win_idx   = idx_t'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters.
// A requester is granted for a whole burst; bursts rotate round-robin.
// Optional feature macro: UART_ARB_FRAME_HDR_EN (header byte 8'hA0|i sent
// before each new grant so the host can demultiplex streams).
// Ports:
//   top_clk, rst            clock, synchronous active-high reset
//   req/req_start/req_last  per-requester burst request, byte strobe, last flag
//   req_data                byte of requester i at [8*i+7:8*i]
//   gnt, req_done_tick      one-hot grant, byte-done routed to the grantee
//   tx_start/tx_bus         to UART TX core
//   tx_done_tick            from UART TX core
//   err_overrun/err_timeout sticky error flags
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant; pick next requester from rr pointer
// ST_HDR   | header byte in flight for the chosen requester (gnt still 0)
// ST_GRANT | requester owns the TX, bytes forwarded one at a time
// ST_DRAIN | last byte of burst in flight, release on its done tick
module uart_tx_arbiter
  import uart_arb_defs_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int TW           = 11
) (
  input  logic               top_clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_start,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   req_done_tick,
  output logic               tx_start,
  output logic [7:0]         tx_bus,
  input  logic               tx_done_tick,
  output logic               err_overrun,
  output logic               err_timeout
);

  localparam logic [TW-1:0]    TMR_LOAD = TW'(HOLD_TIMEOUT - 1);
  localparam logic [N_REQ-1:0] OH_ONE   = N_REQ'(1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  idx_t             idx_q, idx_d;
  idx_t             rr_ptr_q, rr_ptr_d;
  logic             busy_q, busy_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_bus_q, tx_bus_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             err_overrun_q, err_overrun_d;
  logic             err_timeout_q, err_timeout_d;

  logic [N_REQ-1:0] win_oh;
  idx_t             win_idx;
  logic             win_any;

  logic             done, busy_now, g_start, g_last, g_req, accept, rel;
  logic [7:0]       g_data;
  idx_t             nxt_ptr;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req     (req),
    .ptr     (rr_ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  // Everything about the granted requester is taken through the one-hot
  // grant mask, so no variable indexing is needed.
  always_comb begin
    done     = tx_done_tick & busy_q;
    // A done tick in the same cycle frees the TX for a new byte.
    busy_now = busy_q & ~tx_done_tick;
    g_start  = |(req_start & gnt_q);
    g_last   = |(req_last & gnt_q);
    g_req    = |(req & gnt_q);
    g_data   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) g_data = g_data | req_data[8*i +: 8];
    end
    accept  = (state_q == ST_GRANT) && g_start && !busy_now;
    nxt_ptr = (idx_q == idx_t'(N_REQ - 1)) ? '0 : idx_q + idx_t'(1);
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    idx_d         = idx_q;
    rr_ptr_d      = rr_ptr_q;
    busy_d        = done ? 1'b0 : busy_q;
    tx_start_d    = 1'b0;
    tx_bus_d      = tx_bus_q;
    tmr_d         = tmr_q;
    err_timeout_d = err_timeout_q;
    rel           = 1'b0;
    // Any strobe that is not the one accepted byte is dropped and flagged.
    err_overrun_d = err_overrun_q | (|(req_start & ~(accept ? gnt_q : '0)));

    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          idx_d = win_idx;
`ifdef UART_ARB_FRAME_HDR_EN
          state_d    = ST_HDR;
          tx_start_d = 1'b1;
          tx_bus_d   = hdr_byte(win_idx);
          busy_d     = 1'b1;
`else
          state_d = ST_GRANT;
          gnt_d   = win_oh;
          tmr_d   = TMR_LOAD;
`endif
        end
      end
`ifdef UART_ARB_FRAME_HDR_EN
      ST_HDR: begin
        if (done) begin
          state_d = ST_GRANT;
          gnt_d   = OH_ONE << idx_q;
          tmr_d   = TMR_LOAD;
        end
      end
`endif
      ST_GRANT: begin
        if (accept) begin
          tx_start_d = 1'b1;
          tx_bus_d   = g_data;
          busy_d     = 1'b1;
          tmr_d      = TMR_LOAD;
          if (g_last) state_d = ST_DRAIN;
        end else if (!busy_now) begin
          if (tmr_q == '0) begin
            rel           = 1'b1;
            err_timeout_d = 1'b1;
          end else if (!g_req) begin
            rel = 1'b1;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (done) rel = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rel) begin
      gnt_d    = '0;
      rr_ptr_d = nxt_ptr;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge top_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      idx_q         <= '0;
      rr_ptr_q      <= '0;
      busy_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_bus_q      <= 8'h00;
      tmr_q         <= '0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      idx_q         <= idx_d;
      rr_ptr_q      <= rr_ptr_d;
      busy_q        <= busy_d;
      tx_start_q    <= tx_start_d;
      tx_bus_q      <= tx_bus_d;
      tmr_q         <= tmr_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign gnt           = gnt_q;
  assign req_done_tick = done ? gnt_q : '0;
  assign tx_start      = tx_start_q;
  assign tx_bus        = tx_bus_q;
  assign err_overrun   = err_overrun_q;
  assign err_timeout   = err_timeout_q;

endmodule
